seg_scan_driver: RTL and testbench

- Parametrised, time-multiplexed hex driver for a common-anode 7-segment bank, N_DIGITS wide.
- Digits are scanned one at a time by a refresh divider instead of being selected statically.
- New over the static selector: double-buffered load, frame-aligned commit, per-digit enable and decimal point, leading-zero blanking, and an inter-digit anti-ghost blanking gap.
- Sits between the switch/counter datapath and the board display pins.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_scan_timer.sv | 57 +++++
 rtl/seg_scan_driver.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern, hex glyph table, encoder.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp, g..a}; entry 0 is the least significant byte.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h98, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_encode(input logic [3:0] nibble, input logic dp);
    logic [7:0] seg;
    seg    = SEG_TABLE[nibble];
    seg[7] = ~dp;
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timing: slot divider, digit index, start-of-slot blank window and frame wrap/tick.
module seg_scan_timer #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 2,
  localparam int unsigned IdxW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int unsigned DivW     = $clog2(SCAN_DIV)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [IdxW-1:0] idx_o,
  output logic            blank_o,
  output logic            wrap_o,
  output logic            frame_tick_o
);

  logic [DivW-1:0] div_q, div_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            frame_tick_q;
  logic            slot_end;
  logic            last_digit;

  always_comb begin
    slot_end   = (div_q == DivW'(SCAN_DIV - 1));
    last_digit = (idx_q == IdxW'(N_DIGITS - 1));
    div_d      = slot_end ? '0 : div_q + DivW'(1);
    idx_d      = idx_q;
    if (slot_end) begin
      idx_d = last_digit ? '0 : idx_q + IdxW'(1);
    end
  end

  assign wrap_o = slot_end & last_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      frame_tick_q <= wrap_o;
    end
  end

  // With no blank window the compare would be constant-false, so tie it off explicitly.
  if (BLANK_CYC == 0) begin : g_no_blank
    assign blank_o = 1'b0;
  end else begin : g_blank
    assign blank_o = (div_q < DivW'(BLANK_CYC));
  end

  assign idx_o        = idx_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex driver for a common-anode 7-segment bank with double-buffered load.
// Optional digit blinking is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_driver #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYC    = 2
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  lzb_en,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink_mask,
`endif
  output logic [7:0]            seg_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_tick,
  output logic                  busy
);
  import seg_pkg::*;

  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  if (N_DIGITS < 1 || N_DIGITS > 8 || SCAN_DIV < 2 || BLANK_CYC >= SCAN_DIV) begin : g_param_check
    $error("seg_scan_driver: illegal N_DIGITS/SCAN_DIV/BLANK_CYC");
  end

  logic [IdxW-1:0] idx;
  logic            slot_blank;
  logic            wrap;

  seg_scan_timer #(
    .N_DIGITS  (N_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx_o        (idx),
    .blank_o      (slot_blank),
    .wrap_o       (wrap),
    .frame_tick_o (frame_tick)
  );

  // Double buffer: pending is written by load, copied to active only at frame wrap.
  logic [4*N_DIGITS-1:0] val_act_q, val_act_d, val_pend_q, val_pend_d;
  logic [N_DIGITS-1:0]   dp_act_q, dp_act_d, dp_pend_q, dp_pend_d;
  logic                  busy_q, busy_d;

  always_comb begin
    val_act_d  = val_act_q;
    dp_act_d   = dp_act_q;
    val_pend_d = val_pend_q;
    dp_pend_d  = dp_pend_q;
    busy_d     = busy_q;
    if (wrap) begin
      val_act_d = val_pend_q;
      dp_act_d  = dp_pend_q;
      busy_d    = 1'b0;
    end
    // A load on the wrap cycle lands in pending after the old pending has been committed.
    if (load) begin
      val_pend_d = value_in;
      dp_pend_d  = dp_in;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_act_q  <= '0;
      dp_act_q   <= '0;
      val_pend_q <= '0;
      dp_pend_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      val_act_q  <= val_act_d;
      dp_act_q   <= dp_act_d;
      val_pend_q <= val_pend_d;
      dp_pend_q  <= dp_pend_d;
      busy_q     <= busy_d;
    end
  end

  logic blink_off;

`ifdef SEG_SCAN_BLINK_EN
  localparam int unsigned BfW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (BLINK_FRAMES < 1) begin : g_blink_check
    $error("seg_scan_driver: BLINK_FRAMES must be >= 1");
  end

  logic [BfW-1:0] frame_cnt_q, frame_cnt_d;
  logic           blink_phase_q, blink_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      if (frame_cnt_q == BfW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + BfW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_off = ~blink_phase_q & blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [3:0]          nibble;
  logic                higher_nz;
  logic                lz_blank;
  logic                visible;
  logic [31:0]         idx_ext;

  always_comb begin
    idx_ext   = 32'(idx);
    nibble    = val_act_q[{idx, 2'b00} +: 4];
    // Digit idx is a leading zero only if it and every more significant nibble are zero.
    higher_nz = 1'b0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (j >= idx_ext && val_act_q[4*j +: 4] != 4'h0) begin
        higher_nz = 1'b1;
      end
    end
    lz_blank = lzb_en & (idx != '0) & ~higher_nz;
    visible  = ~slot_blank & digit_en[idx] & ~lz_blank & ~blink_off;
    seg_d    = SEG_BLANK;
    an_d     = '1;
    if (visible) begin
      seg_d = seg_encode(nibble, dp_act_q[idx]);
      an_d  = ~(N_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign an_out  = an_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised bench for seg_scan_driver against a time-indexed behavioural display model.
module tb_seg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned BC = 1;
  localparam int unsigned FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  digit_en;
  logic        lzb_en;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_tick;
  logic        busy;
`ifdef SEG_SCAN_BLINK_EN
  logic [3:0]  blink_mask = 4'h0;
`endif

  seg_scan_driver #(
    .N_DIGITS  (ND),
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .digit_en   (digit_en),
    .lzb_en     (lzb_en),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: t counts clock edges since reset release; slot/digit/frame follow by division.
  logic [7:0]  hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int unsigned t;
  int unsigned ph;
  int unsigned dg;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_pdp;
  logic        m_busy;
  logic [3:0]  nib;
  logic        vis;
  logic [7:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_ft, e_busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0; m_val = '0; m_pval = '0; m_dp = '0; m_pdp = '0; m_busy = 1'b0;
      e_seg = 8'hFF; e_an = 4'hF; e_ft = 1'b0; e_busy = 1'b0;
    end else begin
      ph    = t % SD;
      dg    = (t / SD) % ND;
      e_seg = 8'hFF;
      e_an  = 4'hF;
      if (ph >= BC) begin
        nib = 4'(m_val >> (4 * dg));
        vis = digit_en[dg] && !(lzb_en && dg != 0 && (m_val >> (4 * dg)) == 16'h0);
        if (vis) begin
          e_an  = ~(4'b0001 << dg);
          e_seg = hex_tbl[nib] & (m_dp[dg] ? 8'h7F : 8'hFF);
        end
      end
      e_ft = ((t % FR) == FR - 1);
      if (e_ft) begin
        m_val = m_pval; m_dp = m_pdp; m_busy = 1'b0;
      end
      if (load) begin
        m_pval = value_in; m_pdp = dp_in; m_busy = 1'b1;
      end
      e_busy = m_busy;
      t++;
    end
    #1;
    check_eq("an_out", 32'(an_out), 32'(e_an));
    check_eq("seg_out", 32'(seg_out), 32'(e_seg));
    check_eq("frame_tick", 32'(frame_tick), 32'(e_ft));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("an_onehot", 32'($countones(~an_out) <= 1), 32'd1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_commit_cycle();
    int k;
    k = 0;
    while ((t % FR) != FR - 1 && k < FR + 2) begin
      @(negedge clk);
      k++;
    end
    check_eq("wait_commit", 32'((t % FR) == FR - 1), 32'd1);
  endtask

  initial begin
    int k;
    value_in = '0; dp_in = '0; load = 1'b0; digit_en = 4'hF; lzb_en = 1'b0; rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(FR + 2);

    cyc(5);
    do_load(16'h1A3F, 4'b0100);
    cyc(2 * FR);

    do_load(16'h1111, 4'h0);
    cyc(3);
    do_load(16'h2222, 4'h0);
    cyc(2 * FR);

    wait_commit_cycle();
    do_load(16'h3333, 4'b1001);
    cyc(2 * FR);

    lzb_en = 1'b1;
    do_load(16'h0050, 4'h0);
    cyc(2 * FR);
    do_load(16'h0000, 4'hF);
    cyc(2 * FR);
    lzb_en = 1'b0;

    digit_en = 4'b1010;
    do_load(16'h4567, 4'h0);
    cyc(2 * FR);
    digit_en = 4'hF;

    repeat (1500) begin
      @(negedge clk);
      load     = ($urandom_range(0, 9) == 0);
      value_in = 16'($urandom) >> $urandom_range(0, 16);
      dp_in    = 4'($urandom);
      if ($urandom_range(0, 31) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0) lzb_en = 1'($urandom);
    end
    @(negedge clk);
    load = 1'b0; digit_en = 4'hF; lzb_en = 1'b0;

    do_load(16'h8888, 4'hF);
    k = 0;
    while (an_out != 4'b1101 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("wait_an_1101", 32'(an_out), 32'h0000_000D);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_an", 32'(an_out), 32'h0000_000F);
    check_eq("async_seg", 32'(seg_out), 32'h0000_00FF);
    check_eq("async_ft", 32'(frame_tick), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(FR + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
